ctrl_batch_rev: RTL

CTRL_BATCH_REV -- requirements
Module: ctrl_batch_rev

---
 rtl/ctrl_batch_rev.sv | 58 +++++
 1 files changed

// File: rtl/ctrl_batch_rev.sv
// ctrl_batch_rev: ping-pong batch buffer emitting each DEPTH-sample batch time-reversed
module ctrl_batch_rev #(
  parameter int N = 4,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [N-1:0] in_ctrl,
  output logic         rev_valid,
  output logic [N-1:0] rev_sel,
  output logic         batch_start,
  output logic         primed
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] last = AW'(DEPTH - 1);
  localparam logic [0:0] s_fill = 1'b0;
  localparam logic [0:0] s_run = 1'b1;
  logic [N-1:0] bank0 [DEPTH];
  logic [N-1:0] bank1 [DEPTH];
  logic [AW-1:0] wr_cnt, rd_cnt;
  logic [0:0] state;
  logic wsel;
  logic [N-1:0] rd_data;
  assign rd_data = wsel ? bank0[rd_cnt] : bank1[rd_cnt];
  assign primed = state == s_run;
  always_ff @(posedge clk)
    if (in_valid && !rst) begin
      if (wsel) bank1[wr_cnt] <= in_ctrl;
      else bank0[wr_cnt] <= in_ctrl;
    end
  // the last read of a batch (rd_cnt=0) coincides with the swap, so reloading rd_cnt loses nothing
  always_ff @(posedge clk)
    if (rst) begin
      state <= s_fill;
      wr_cnt <= '0;
      rd_cnt <= last;
      wsel <= 1'b0;
      rev_valid <= 1'b0;
      rev_sel <= '0;
      batch_start <= 1'b0;
    end else begin
      rev_valid <= in_valid && state == s_run;
      batch_start <= in_valid && state == s_run && rd_cnt == last;
      if (in_valid) begin
        wr_cnt <= wr_cnt + 1'b1;
        if (state == s_run) begin
          rev_sel <= rd_data;
          rd_cnt <= rd_cnt - 1'b1;
        end
        if (wr_cnt == last) begin
          wsel <= ~wsel;
          rd_cnt <= last;
          state <= s_run;
        end
      end
    end
endmodule
